// File: rtl/edge_gen_pkg.sv
// edge_gen_pkg: shared state encoding, direction codes and counter width for edge_gen
package edge_gen_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b01,
    HOLD = 2'b10
  } state_t;
  localparam logic DIR_RISE = 1'b1;
  localparam logic DIR_FALL = 1'b0;
  localparam int STAT_W = 16;
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/edge_gen_hold_timer.sv
// edge_gen_hold_timer: load/decrement counter; expire flags the last held cycle
module edge_gen_hold_timer #(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  output logic              expire
);
  logic [HOLD_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign expire = (cnt == HOLD_W'(1));
endmodule

// File: rtl/edge_gen.sv
// edge_gen: rise/fall command to level generator with per-edge minimum hold; EDGE_GEN_STATS_EN adds edge counters
module edge_gen
  import edge_gen_pkg::*;
#(
  parameter int   HOLD_W     = 8,
  parameter int   MIN_HOLD   = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dir,
  input  logic [HOLD_W-1:0] req_hold,
  output logic              sig,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic              busy,
`ifdef EDGE_GEN_STATS_EN
  input  logic              stats_clr,
  output logic [STAT_W-1:0] rise_cnt,
  output logic [STAT_W-1:0] fall_cnt,
`endif
  output logic              err
);
  localparam logic [HOLD_W-1:0] MIN_H = HOLD_W'(MIN_HOLD);
  state_t state_q, state_d;
  logic accept, toggle, redundant, go_hold, expire;
  logic [HOLD_W-1:0] hold_eff;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q == HOLD);
  assign accept    = req_valid && req_ready;
  assign toggle    = accept && (req_dir != sig);
  assign redundant = accept && (req_dir == sig);
  assign hold_eff  = (req_hold < MIN_H) ? MIN_H : req_hold;
  assign go_hold   = toggle && (hold_eff != HOLD_W'(1));
  edge_gen_hold_timer #(.HOLD_W(HOLD_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (toggle),
    .load_val (hold_eff - 1'b1),
    .expire   (expire)
  );
  always_comb begin
    state_d = IDLE;
    if (state_q == IDLE) state_d = go_hold ? HOLD : IDLE;
    else if (state_q == HOLD) state_d = expire ? IDLE : HOLD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sig        <= IDLE_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig        <= toggle ? ~sig : sig;
      rise_pulse <= toggle && (req_dir == DIR_RISE);
      fall_pulse <= toggle && (req_dir == DIR_FALL);
      err        <= redundant;
    end
  end
`ifdef EDGE_GEN_STATS_EN
  // counters advance on the same edge that raises the matching pulse, so a clear there wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
    end else if (stats_clr) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
    end else begin
      rise_cnt <= (toggle && req_dir == DIR_RISE) ? sat_inc(rise_cnt) : rise_cnt;
      fall_cnt <= (toggle && req_dir == DIR_FALL) ? sat_inc(fall_cnt) : fall_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_edge_gen.sv
// tb_edge_gen: directed scoreboard bench for edge_gen; outputs packed as {sig,rise,fall,err,busy,ready}
module tb_edge_gen;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_dir = 1'b0, req_ready;
  logic [7:0] req_hold = '0;
  logic sig, rise_pulse, fall_pulse, busy, err;
  int checks = 0, errors = 0;
  logic [5:0] sb[$];
`ifdef EDGE_GEN_STATS_EN
  logic stats_clr = 1'b0;
  logic [15:0] rise_cnt, fall_cnt;
`endif
  edge_gen dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dir(req_dir), .req_hold(req_hold), .sig(sig), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .busy(busy),
`ifdef EDGE_GEN_STATS_EN
    .stats_clr(stats_clr), .rise_cnt(rise_cnt), .fall_cnt(fall_cnt),
`endif
    .err(err)
  );
  always #5 clk = ~clk;
  wire [5:0] obs = {sig, rise_pulse, fall_pulse, err, busy, req_ready};
  task automatic check(input string tag);
    logic [5:0] e;
    e = sb.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask
  task automatic step(input logic v, input logic d, input logic [7:0] h, input logic [5:0] e, input string tag);
    @(negedge clk);
    req_valid = v; req_dir = d; req_hold = h;
    sb.push_back(e);
    @(posedge clk);
    #1 check(tag);
  endtask
`ifdef EDGE_GEN_STATS_EN
  task automatic cnt_check(input logic [15:0] r, input logic [15:0] f, input string tag);
    checks++;
    assert ({rise_cnt, fall_cnt} === {r, f}) else begin
      errors++;
      $error("FAIL %s: observed %0d/%0d expected %0d/%0d", tag, rise_cnt, fall_cnt, r, f);
    end
  endtask
`endif
  always @(negedge clk) if (!rst) begin
    checks++;
    assert (!(rise_pulse && fall_pulse) && !(err && (rise_pulse || fall_pulse))) else begin
      errors++;
      $error("FAIL exclusive: observed r%b f%b e%b expected at most one", rise_pulse, fall_pulse, err);
    end
  end
  initial begin
    #12;
    sb.push_back(6'b000001);
    check("reset");
    @(negedge clk) rst = 1'b0;
    step(1, 1, 8'd4, 6'b110010, "rise_h4");
    step(1, 0, 8'd0, 6'b100010, "hold1");
    step(1, 0, 8'd0, 6'b100010, "hold2");
    step(1, 0, 8'd0, 6'b100001, "hold_end");
    step(1, 0, 8'd0, 6'b001001, "fall_e5");
    step(1, 1, 8'd0, 6'b110001, "alt_r1");
    step(1, 0, 8'd0, 6'b001001, "alt_f1");
    step(1, 1, 8'd0, 6'b110001, "alt_r2");
    step(1, 0, 8'd0, 6'b001001, "alt_f2");
    step(1, 1, 8'd1, 6'b110001, "rise_h1");
    step(1, 1, 8'd0, 6'b100101, "redundant");
    step(0, 0, 8'd0, 6'b100001, "idle");
    step(1, 0, 8'd2, 6'b001010, "fall_h2");
    step(1, 1, 8'd0, 6'b000001, "fall_h2_end");
    step(1, 1, 8'd10, 6'b110010, "rise_h10");
    step(1, 0, 8'd0, 6'b100010, "h10_c1");
    step(0, 0, 8'd0, 6'b100010, "h10_c2");
    @(negedge clk) rst = 1'b1;
    #1 sb.push_back(6'b000001);
    check("async_rst");
    step(0, 0, 8'd0, 6'b000001, "in_rst");
    @(negedge clk) rst = 1'b0;
    sb.push_back(6'b110001);
    req_valid = 1; req_dir = 1; req_hold = 0;
    @(posedge clk);
    #1 check("post_rst_rise");
    step(0, 0, 8'd0, 6'b100001, "post_rst_idle");
`ifdef EDGE_GEN_STATS_EN
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'd0, 6'b110001, "st_rise");
      step(1, 0, 8'd0, 6'b001001, "st_fall");
    end
    cnt_check(16'd3, 16'd3, "cnt_3_3");
    @(negedge clk) stats_clr = 1'b1;
    step(1, 1, 8'd0, 6'b110001, "clr_rise");
    cnt_check(16'd0, 16'd0, "cnt_clr");
    @(negedge clk) stats_clr = 1'b0;
    force dut.rise_cnt = 16'hFFFE;
    @(negedge clk) release dut.rise_cnt;
    step(1, 0, 8'd0, 6'b001001, "sat_f");
    step(1, 1, 8'd0, 6'b110001, "sat_r1");
    step(1, 0, 8'd0, 6'b001001, "sat_f2");
    step(1, 1, 8'd0, 6'b110001, "sat_r2");
    cnt_check(16'hFFFF, 16'd2, "cnt_sat");
`endif
    @(negedge clk) req_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
